// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit-side blocks: byte width,
// idle line byte and the arbiter state encoding.
package spart_pkg;

  localparam int SPART_BYTE_W = 8;
  localparam logic [SPART_BYTE_W-1:0] SPART_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } spart_state_e;

endpackage

// File: rtl/spart_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching ptr+1,
// ptr+2, ... with wrap-around modulo NREQ (NREQ need not be a power of two).
module spart_rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  int            c;
  logic [PW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c    = (int'(ptr) + k) % NREQ;
      cand = PW'(c);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spart_tx_arb.sv
// Round-robin, packet-locking arbiter sharing one SPART transmitter among
// NREQ byte requesters; sequences write/tx_data against the transmitter's tbr.
module spart_tx_arb
  import spart_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int TMO  = 1024,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*SPART_BYTE_W-1:0] req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  output logic                         write,
  output logic [SPART_BYTE_W-1:0]      tx_data,
  input  logic                         tbr,
  output logic [GW-1:0]                grant_id,
  output logic                         locked,
  output logic                         busy
);

  localparam int            CW    = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  spart_state_e  state;
  logic [GW-1:0] ptr;
  logic [CW-1:0] stall_cnt;
  logic [NREQ-1:0] cand;
  logic          found;
  logic [GW-1:0] winner;
  logic          accept;
  logic          stall;
  logic          tmo_hit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == TMO_C) ? v : v + CW'(1);
  endfunction

  // While locked, only the owning requester may compete.
  always_comb begin
    cand = req_valid;
    if (locked) cand = req_valid & (NREQ'(1) << grant_id);
  end

  spart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (cand),
    .ptr   (ptr),
    .found (found),
    .idx   (winner)
  );

  always_comb begin
    accept    = (state == IDLE) && tbr && found;
    req_ready = accept ? (NREQ'(1) << winner) : '0;
    stall     = (state == IDLE) && locked && !req_valid[grant_id];
    tmo_hit   = (TMO != 0) && stall && (sat_inc(stall_cnt) == TMO_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      write     <= 1'b0;
      tx_data   <= SPART_IDLE_BYTE;
      grant_id  <= '0;
      locked    <= 1'b0;
      busy      <= 1'b0;
      ptr       <= GW'(NREQ - 1);
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data   <= req_data[SPART_BYTE_W*winner +: SPART_BYTE_W];
            grant_id  <= winner;
            locked    <= !req_last[winner];
            if (req_last[winner]) ptr <= winner;
            stall_cnt <= '0;
            write     <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end else if (tmo_hit) begin
            // Owner went quiet mid-packet: release it and rotate past it.
            locked    <= 1'b0;
            ptr       <= grant_id;
            stall_cnt <= '0;
          end else if (stall && (TMO != 0)) begin
            stall_cnt <= sat_inc(stall_cnt);
          end
        end
        LOAD: begin
          // tbr drops only after the transmitter has taken the byte on its tick.
          if (!tbr) begin
            write <= 1'b0;
            state <= SEND;
          end
        end
        SEND: begin
          if (tbr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          write <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
